// File: rtl/l2_pkg.sv
// Shared types and defaults for the L2 line-refill requester.
package l2_pkg;

    localparam int L2_ADDR_W     = 32;
    localparam int L2_DATA_W     = 32;
    localparam int L2_BEATS      = 8;
    // Widest address line_base() handles; callers cast in and out.
    localparam int L2_MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } l2_state_e;

    // Clears the low off_w bits of a word address (line-aligned base).
    function automatic logic [L2_MAX_ADDR_W-1:0] line_base(
        input logic [L2_MAX_ADDR_W-1:0] addr,
        input int unsigned              off_w
    );
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/l2_line_buf.sv
// BEATS-entry line buffer: one word written per cycle by index, whole line
// presented on a flat output bus.
module l2_line_buf #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 8,
    parameter int IDX_W  = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       wdata,
    output logic [BEATS*DATA_W-1:0] line
);

    logic [DATA_W-1:0] words [BEATS];

    // Write one word per accepted beat.
    // NOTE: this array is a bank of flops, not a RAM, so it can and must be
    // reset -- the line output is defined as all-zero out of reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) words[i] <= '0;
        end else if (we) begin
            words[idx] <= wdata;
        end
    end

    // Flatten: word i lands at bits [i*DATA_W +: DATA_W].
    always_comb begin
        line = '0;
        for (int i = 0; i < BEATS; i++) line[i*DATA_W +: DATA_W] = words[i];
    end

endmodule

// File: rtl/l2_refill_ctrl.sv
// L2 line-fill requester: captures a miss, issues one burst read, assembles
// the returned beats into a line and pulses line_valid when it is complete.
// Optional build macro L2_REFILL_CWF_EN enables critical-word-first bursts.
module l2_refill_ctrl
    import l2_pkg::*;
#(
    parameter int ADDR_W = L2_ADDR_W,
    parameter int DATA_W = L2_DATA_W,
    parameter int BEATS  = L2_BEATS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [ADDR_W-1:0]       miss_addr,
    output logic                    busy,
    output logic                    line_valid,
    output logic [ADDR_W-1:0]       line_addr,
    output logic [BEATS*DATA_W-1:0] line_data,
    output logic                    crit_valid,
    output logic [DATA_W-1:0]       crit_data,
    output logic                    mem_read,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    err
);

    localparam int OFF_W = $clog2(BEATS);
    localparam int CNT_W = OFF_W + 1;

    l2_state_e         state, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0]  count_q;
    logic [OFF_W-1:0]  wr_idx;
    logic              capture, beat_we, last_beat;
    logic              mem_read_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;

    assign base_d = ADDR_W'(line_base(L2_MAX_ADDR_W'(miss_addr), OFF_W));
`ifdef L2_REFILL_CWF_EN
    assign start_d = miss_addr[OFF_W-1:0];
`else
    assign start_d = '0;
`endif

    // Burst wraps inside the line: the OFF_W-bit sum drops the carry.
    assign wr_idx  = start_q + count_q[OFF_W-1:0];
    assign capture = (state == IDLE) && miss_req;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and beat-acceptance decode.
    // NOTE: every output of this block gets a default first; a path that
    // skipped one would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        beat_we   = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            IDLE: if (miss_req) state_d = FILL;
            FILL: begin
                if (mem_rvalid) begin
                    beat_we = 1'b1;
                    if (count_q == CNT_W'(BEATS - 1)) begin
                        last_beat = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, burst request, beat counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            start_q    <= '0;
            count_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (capture) begin
                base_q     <= base_d;
                start_q    <= start_d;
                mem_read_q <= 1'b1;
                mem_addr_q <= base_d + ADDR_W'(start_d);
            end else if (last_beat) begin
                mem_read_q <= 1'b0;
            end
            if (last_beat)    count_q <= '0;
            else if (beat_we) count_q <= count_q + CNT_W'(1);
            // A beat outside FILL is a protocol violation; it is dropped.
            if (mem_rvalid && (state != FILL)) err_q <= 1'b1;
        end
    end

`ifdef L2_REFILL_CWF_EN
    logic              crit_valid_q;
    logic [DATA_W-1:0] crit_data_q;

    // Forward the first beat of the burst (the missed word) one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= beat_we && (count_q == '0);
            if (beat_we && (count_q == '0)) crit_data_q <= mem_rdata;
        end
    end

    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

    l2_line_buf #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (beat_we),
        .idx   (wr_idx),
        .wdata (mem_rdata),
        .line  (line_data)
    );

    assign busy       = (state != IDLE);
    assign line_valid = (state == DONE);
    assign line_addr  = base_q;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;
    assign err        = err_q;

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Directed self-checking bench for l2_refill_ctrl (ADDR_W=32, DATA_W=32,
// BEATS=8). Expected values follow the build macro L2_REFILL_CWF_EN.
module tb_l2_refill_ctrl;

`ifdef L2_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          busy;
    logic          line_valid;
    logic [31:0]   line_addr;
    logic [255:0]  line_data;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          mem_read;
    logic [31:0]   mem_addr;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    l2_refill_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .BEATS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .line_valid (line_valid),
        .line_addr  (line_addr),
        .line_data  (line_data),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete refill. Beat data = dbase + destination word index, so a
    // correctly assembled line always holds dbase+i in word i. gapped inserts
    // 1..3 idle cycles between beats; hold keeps miss_req high and moves
    // miss_addr to next_addr while the fill is in progress.
    task automatic run_fill(input string name, input logic [31:0] addr,
                            input logic [31:0] dbase, input bit gapped,
                            input bit hold, input logic [31:0] next_addr);
        logic [31:0]  base;
        logic [31:0]  exp_ma;
        logic [2:0]   st;
        logic [2:0]   widx;
        logic [255:0] exp_line;
        base = addr & 32'hFFFF_FFF8;
        st   = CWF ? addr[2:0] : 3'd0;
        exp_ma = base + {29'd0, st};
        for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = dbase + i;

        miss_req  = 1'b1;
        miss_addr = addr;
        tick();
        if (hold) miss_addr = next_addr;
        else      miss_req  = 1'b0;

        vectors++;
        if ({busy, mem_read, line_valid} !== 3'b110) begin
            $display("FAIL %s fill_start: busy/mem_read/line_valid=%b want 110", name, {busy, mem_read, line_valid});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== exp_ma) begin
            $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, exp_ma);
            miscompares++;
        end

        for (int k = 0; k < 8; k++) begin
            if (gapped && k != 0) begin
                for (int g = 0; g < (k % 3) + 1; g++) begin
                    tick();
                    vectors++;
                    if ({mem_read, line_valid} !== 2'b10) begin
                        $display("FAIL %s gap_k%0d: mem_read/line_valid=%b want 10", name, k, {mem_read, line_valid});
                        miscompares++;
                    end
                end
            end
            widx       = st + 3'(k);
            mem_rvalid = 1'b1;
            mem_rdata  = dbase + {29'd0, widx};
            tick();
            mem_rvalid = 1'b0;

            if (k == 0) begin
                vectors++;
                if (crit_valid !== CWF || crit_data !== (CWF ? dbase + {29'd0, st} : 32'd0)) begin
                    $display("FAIL %s crit_first: got %b/%h want %b/%h", name, crit_valid, crit_data, CWF, CWF ? dbase + {29'd0, st} : 32'd0);
                    miscompares++;
                end
            end
            if (k == 1) begin
                vectors++;
                if (crit_valid !== 1'b0) begin
                    $display("FAIL %s crit_once: crit_valid=%b want 0", name, crit_valid);
                    miscompares++;
                end
            end
            if (k < 7) begin
                vectors++;
                if (line_valid !== 1'b0) begin
                    $display("FAIL %s early_valid_k%0d: line_valid=%b want 0", name, k, line_valid);
                    miscompares++;
                end
            end
        end

        // DONE cycle.
        vectors++;
        if ({line_valid, busy, mem_read} !== 3'b110) begin
            $display("FAIL %s done: line_valid/busy/mem_read=%b want 110", name, {line_valid, busy, mem_read});
            miscompares++;
        end
        vectors++;
        if (line_addr !== base) begin
            $display("FAIL %s line_addr: got %h want %h", name, line_addr, base);
            miscompares++;
        end
        vectors++;
        if (line_data !== exp_line) begin
            $display("FAIL %s line_data: got %h want %h", name, line_data, exp_line);
            miscompares++;
        end

        // IDLE again one cycle later, line held.
        tick();
        vectors++;
        if ({busy, line_valid, err} !== 3'b000) begin
            $display("FAIL %s after_done: busy/line_valid/err=%b want 000", name, {busy, line_valid, err});
            miscompares++;
        end
        vectors++;
        if (line_data !== exp_line || line_addr !== base) begin
            $display("FAIL %s line_hold: got %h @%h want %h @%h", name, line_data, line_addr, exp_line, base);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        miss_req   = 1'b0;
        miss_addr  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        vectors++;
        if ({busy, line_valid, crit_valid, mem_read, err} !== 5'b0) begin
            $display("FAIL reset_flags: busy/lv/cv/rd/err=%b want 00000", {busy, line_valid, crit_valid, mem_read, err});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 32'd0 || line_addr !== 32'd0 || crit_data !== 32'd0) begin
            $display("FAIL reset_addr: mem_addr=%h line_addr=%h crit_data=%h want 0", mem_addr, line_addr, crit_data);
            miscompares++;
        end
        vectors++;
        if (line_data !== 256'd0) begin
            $display("FAIL reset_line: got %h want 0", line_data);
            miscompares++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fill;
        run_fill("basic", 32'h13, 32'hA0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_gapped;
        run_fill("gapped", 32'h13, 32'hA0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        // First fill ends in the IDLE cycle with miss_req still high for 0x40.
        run_fill("b2b_first", 32'h20, 32'h120, 1'b0, 1'b1, 32'h40);
        run_fill("b2b_second", 32'h40, 32'h140, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_cwf_order;
        // With CWF the beats arrive as 0xB5,0xB6,0xB7,0xB0..0xB4.
        run_fill("cwf", 32'h15, 32'hB0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        run_fill("wrap", 32'hFFFF_FFFF, 32'hD0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        int pulses;
        miss_req  = 1'b1;
        miss_addr = 32'h50;
        tick();
        miss_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hE0 + k;
            tick();
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, line_valid, crit_valid, mem_read, err} !== 5'b0) begin
            $display("FAIL midrst_flags: busy/lv/cv/rd/err=%b want 00000", {busy, line_valid, crit_valid, mem_read, err});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 32'd0 || line_addr !== 32'd0 || line_data !== 256'd0 || crit_data !== 32'd0) begin
            $display("FAIL midrst_data: mem_addr=%h line_addr=%h line_data=%h crit_data=%h want 0", mem_addr, line_addr, line_data, crit_data);
            miscompares++;
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            $display("FAIL midrst_idle: busy=%b err=%b want 0 0", busy, err);
            miscompares++;
        end
        // Stray beat while IDLE.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL stray_beat: err=%b busy=%b want 1 0", err, busy);
            miscompares++;
        end
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (line_valid === 1'b1 || busy !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses != 0 || err !== 1'b1) begin
            $display("FAIL stray_quiet: activity cycles=%0d err=%b want 0 1", pulses, err);
            miscompares++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (err !== 1'b0) begin
            $display("FAIL err_clear: err=%b want 0", err);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_gapped();
        test_back_to_back();
        test_cwf_order();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
